// File: rtl/pucch_pkg.sv
// rtl/pucch_pkg.sv - shared types and helpers for the PUCCH sequence generator
//
// Contents:
//   CYC_PTS       number of points on the phase circle (24)
//   phase_idx_t   5-bit phase index 0..23
//   phi_code_t    2-bit base-sequence phase code
//   seq_state_t   sequencer FSM states
//   phi_to_base   maps a phase code to 3*phi mod 24
package pucch_pkg;

    localparam int CYC_PTS = 24;

    typedef logic [4:0] phase_idx_t;
    typedef logic [1:0] phi_code_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    // phi in {-3,-1,+1,+3} (units of pi/4) expressed in units of pi/12,
    // folded into 0..23: -9 -> 15, -3 -> 21, 3 -> 3, 9 -> 9.
    function automatic phase_idx_t phi_to_base(input phi_code_t code);
        phase_idx_t base;
        case (code)
            2'b00:   base = 5'd15;
            2'b01:   base = 5'd21;
            2'b10:   base = 5'd3;
            default: base = 5'd9;
        endcase
        return base;
    endfunction

endpackage

// File: rtl/cyc_24.sv
// rtl/cyc_24.sv - 24-point unit-circle lookup, sfix16 (scale 2^15, +1.0 saturates)
//
// Ports:
//   idx  in   5   phase index 0..23 (angle = idx * 15 degrees)
//   re   out  16  cos(angle), two's complement
//   im   out  16  sin(angle), two's complement
module cyc_24 (
    input  logic [4:0]  idx,
    output logic [15:0] re,
    output logic [15:0] im
);

    always_comb begin
        re = 16'h0000;
        im = 16'h0000;
        case (idx)
            5'd0:  begin re = 16'h7FFF; im = 16'h0000; end
            5'd1:  begin re = 16'h7BA3; im = 16'h2121; end
            5'd2:  begin re = 16'h6EDA; im = 16'h4000; end
            5'd3:  begin re = 16'h5A82; im = 16'h5A82; end
            5'd4:  begin re = 16'h4000; im = 16'h6EDA; end
            5'd5:  begin re = 16'h2121; im = 16'h7BA3; end
            5'd6:  begin re = 16'h0000; im = 16'h7FFF; end
            5'd7:  begin re = 16'hDEDF; im = 16'h7BA3; end
            5'd8:  begin re = 16'hC000; im = 16'h6EDA; end
            5'd9:  begin re = 16'hA57E; im = 16'h5A82; end
            5'd10: begin re = 16'h9126; im = 16'h4000; end
            5'd11: begin re = 16'h845D; im = 16'h2121; end
            5'd12: begin re = 16'h8000; im = 16'h0000; end
            5'd13: begin re = 16'h845D; im = 16'hDEDF; end
            5'd14: begin re = 16'h9126; im = 16'hC000; end
            5'd15: begin re = 16'hA57E; im = 16'hA57E; end
            5'd16: begin re = 16'hC000; im = 16'h9126; end
            5'd17: begin re = 16'hDEDF; im = 16'h845D; end
            5'd18: begin re = 16'h0000; im = 16'h8000; end
            5'd19: begin re = 16'h2121; im = 16'h845D; end
            5'd20: begin re = 16'h4000; im = 16'h9126; end
            5'd21: begin re = 16'h5A82; im = 16'hA57E; end
            5'd22: begin re = 16'h6EDA; im = 16'hC000; end
            5'd23: begin re = 16'h7BA3; im = 16'hDEDF; end
            default: begin re = 16'h0000; im = 16'h0000; end
        endcase
    end

endmodule

// File: rtl/pucch_mod24_add.sv
// rtl/pucch_mod24_add.sv - modulo-24 adder for operands already in 0..23
//
// Ports:
//   a, b  in   5  operands, each 0..23
//   sum   out  5  (a + b) mod 24
module pucch_mod24_add
    import pucch_pkg::*;
(
    input  phase_idx_t a,
    input  phase_idx_t b,
    output phase_idx_t sum
);

    logic [5:0] raw;

    // Both operands are below 24, so one conditional subtract is enough.
    always_comb begin
        raw = {1'b0, a} + {1'b0, b};
        if (raw >= 6'(CYC_PTS)) begin
            raw = raw - 6'(CYC_PTS);
        end
        sum = raw[4:0];
    end

endmodule

// File: rtl/pucch_seq_gen.sv
// rtl/pucch_seq_gen.sv - PUCCH low-PAPR sequence generator (stream of N_SC phase samples)
//
// Optional feature macro: PUCCH_SEQ_CONJ_EN (adds i_conj, conjugated output).
//
// Ports:
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_start            start request (ignored while busy)
//   i_phi   [2*N_SC]   phase codes, sample n at bits [2n+1:2n]
//   i_m_cs  [4]        cyclic shift, taken mod 12
//   i_conj             (macro only) conjugate the sequence, latched at start
//   o_busy             sequence in progress
//   o_valid/i_ready    output beat handshake
//   o_idx   [5]        phase index of the beat
//   o_re/o_im [16]     sfix16 sample
//   o_last             final beat of the sequence
module pucch_seq_gen
    import pucch_pkg::*;
#(
    parameter int N_SC  = 12,
    parameter int CNT_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [2*N_SC-1:0] i_phi,
    input  logic [3:0]        i_m_cs,
`ifdef PUCCH_SEQ_CONJ_EN
    input  logic              i_conj,
`endif
    output logic              o_busy,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [4:0]        o_idx,
    output logic [15:0]       o_re,
    output logic [15:0]       o_im,
    output logic              o_last
);

    localparam logic [CNT_W-1:0] LAST_N = CNT_W'(N_SC - 1);

    seq_state_t        state;
    seq_state_t        state_nxt;
    logic [2*N_SC-1:0] phi_q;
    phase_idx_t        step_q;
    phase_idx_t        acc_q;
    logic [CNT_W-1:0]  n_q;

    logic              start_ok;
    logic              accept;
    logic              advance;
    logic              load_beat;
    logic              is_last_n;

    logic [3:0]        cs_mod;
    phase_idx_t        step_in;
    logic [CNT_W-1:0]  n_sel;
    phi_code_t         code_sel;
    phase_idx_t        acc_sum;
    phase_idx_t        acc_in;
    phase_idx_t        base_sel;
    phase_idx_t        idx_raw;
    phase_idx_t        idx_fin;
    logic [15:0]       lut_re;
    logic [15:0]       lut_im;

`ifdef PUCCH_SEQ_CONJ_EN
    logic              conj_q;
    logic              conj_sel;
`endif

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = RUN;
            RUN:     if (i_ready && (n_q == LAST_N)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs and control strobes; o_valid is high for the whole RUN state
    always_comb begin
        o_busy    = (state == RUN);
        o_valid   = (state == RUN);
        is_last_n = (n_q == LAST_N);
        start_ok  = (state == IDLE) && i_start;
        accept    = (state == RUN) && i_ready;
        advance   = accept && !is_last_n;
        load_beat = start_ok || advance;
    end

    // Next-beat index: in IDLE the first beat is built straight from the
    // inputs so it can be registered on the same edge that accepts start.
    always_comb begin
        cs_mod  = (i_m_cs >= 4'd12) ? (i_m_cs - 4'd12) : i_m_cs;
        step_in = {cs_mod, 1'b0};

        n_sel    = (state == IDLE) ? '0 : (n_q + 1'b1);
        code_sel = phi_q[1:0];
        for (int k = 0; k < N_SC; k++) begin
            if (n_sel == CNT_W'(k)) begin
                code_sel = phi_q[2*k +: 2];
            end
        end
        if (state == IDLE) begin
            code_sel = i_phi[1:0];
        end

        base_sel = phi_to_base(code_sel);
        acc_in   = (state == IDLE) ? '0 : acc_sum;
    end

    pucch_mod24_add u_acc_add (
        .a   (acc_q),
        .b   (step_q),
        .sum (acc_sum)
    );

    pucch_mod24_add u_idx_add (
        .a   (base_sel),
        .b   (acc_in),
        .sum (idx_raw)
    );

`ifdef PUCCH_SEQ_CONJ_EN
    // Conjugation negates the phase: (24 - idx) mod 24, with 0 staying 0.
    always_comb begin
        conj_sel = (state == IDLE) ? i_conj : conj_q;
        idx_fin  = idx_raw;
        if (conj_sel && (idx_raw != '0)) begin
            idx_fin = 5'(CYC_PTS) - idx_raw;
        end
    end
`else
    assign idx_fin = idx_raw;
`endif

    cyc_24 u_cyc (
        .idx (idx_fin),
        .re  (lut_re),
        .im  (lut_im)
    );

    // Sequence context and output register stage
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            phi_q  <= '0;
            step_q <= '0;
            acc_q  <= '0;
            n_q    <= '0;
            o_idx  <= '0;
            o_re   <= '0;
            o_im   <= '0;
            o_last <= 1'b0;
`ifdef PUCCH_SEQ_CONJ_EN
            conj_q <= 1'b0;
`endif
        end else begin
            if (start_ok) begin
                phi_q  <= i_phi;
                step_q <= step_in;
                acc_q  <= '0;
                n_q    <= '0;
`ifdef PUCCH_SEQ_CONJ_EN
                conj_q <= i_conj;
`endif
            end else if (advance) begin
                acc_q <= acc_sum;
                n_q   <= n_q + 1'b1;
            end else if (accept) begin
                // last beat taken: park the context for the next start
                acc_q  <= '0;
                n_q    <= '0;
                o_last <= 1'b0;
            end

            if (load_beat) begin
                o_idx  <= idx_fin;
                o_re   <= lut_re;
                o_im   <= lut_im;
                o_last <= (n_sel == LAST_N);
            end
        end
    end

endmodule

// File: doc/pucch_seq_gen.md
Name: pucch_seq_gen

Overview:
- Sequences the 24-point unit-circle phase lookup (`cyc_24`) to produce one PUCCH low-PAPR sequence of N_SC complex samples.
- Per sample n: idx(n) = (3*phi(n) + 2*m_cs*n) mod 24. phi(n) is in {-3,-1,1,3} in units of pi/4. m_cs is the cyclic shift, in units of 2*pi/12.
- Sits between the PUCCH format 0/1 control logic (start + parameters) and the RE mapper (AXI-style stream sink).
- Uses an accumulator, not a multiplier, and supports backpressure.

Parameters:
- N_SC, 12, sequence length in subcarriers (2..12).
- CNT_W, 4, width of the sample counter; must satisfy 2^CNT_W >= N_SC.

Ports:
- i_clk  in  1  single clock, rising edge.
- i_rst  in  1  asynchronous reset, active-high.
- i_start  in  1  start request; one-cycle pulse is sufficient.
- i_phi  in  2*N_SC  base-sequence phase codes; bits [2n+1:2n] = code for sample n. Codes 00/01/10/11 mean phi = -3/-1/+1/+3.
- i_m_cs  in  4  cyclic shift 0..11; values 12..15 are taken mod 12.
- o_busy  out  1  high from start acceptance until the last beat is accepted.
- o_valid  out  1  output beat valid.
- i_ready  in  1  sink ready.
- o_idx  out  5  phase index 0..23 of the current beat.
- o_re  out  16  sfix16 real part from `cyc_24`.
- o_im  out  16  sfix16 imaginary part from `cyc_24`.
- o_last  out  1  high on beat n = N_SC-1.

Behaviour:
- Reset: all of the following are 0 asynchronously and stay 0 until reset releases: state=IDLE, o_busy, o_valid, o_last, o_idx, o_re, o_im, counter, accumulator.
- Reset mid-sequence: the sequence is abandoned; no partial output resumes.
- FSM states: IDLE and RUN.
  - IDLE: when i_start=1, latch i_phi and step = 2*(i_m_cs mod 12), which lies in 0..22. Set acc=0, n=0, go to RUN.
  - RUN: when o_valid & i_ready and n = N_SC-1, return to IDLE.
- i_start is ignored while in RUN, including the cycle in which the last beat is accepted. The earliest next start is the cycle after o_busy falls.
- Latency: start accepted at edge T → o_valid=1 at T+1 carrying n=0.
- Output stage: one register stage holding idx, re, im and last.
  - o_re and o_im come from the `cyc_24` output for the computed index, registered together with o_idx.
- Beat advance:
  - On an edge where o_valid & i_ready: n += 1, acc = acc+step (subtract 24 if >= 24), and the next beat is registered. o_valid stays high throughout RUN, so the rate is one beat per cycle.
  - While o_valid & !i_ready: o_idx, o_re, o_im and o_last are held stable.
- Index arithmetic:
  - base = 3*phi mod 24, i.e. code 00→15, 01→21, 10→3, 11→9.
  - idx = base + acc, with base and acc each in 0..23; subtract 24 if the sum is >= 24.
  - All values are unsigned 5-bit; the sum needs 6 bits internally.
- Wrap-around: acc never exceeds 23. step=0 gives a constant idx = base per sample.
- o_last = (n == N_SC-1) and is registered with the beat.
- o_busy = (state == RUN). It falls on the edge where the last beat is accepted, so o_valid falls on that same edge.

Optional Feature:
- Macro: PUCCH_SEQ_CONJ_EN.
- With the macro defined:
  - Adds input port i_conj (1 bit), latched at start.
  - If latched i_conj=1, the final index becomes (24-idx) mod 24, giving the complex conjugate for receiver correlation. Index 0 maps to 0.
  - o_idx, o_re and o_im all reflect the conjugated index.
- Without the macro: no i_conj port and no conjugation logic; behaviour is identical to latched i_conj=0.

Decomposition:
- Shared package pucch_pkg holds:
  - constant CYC_PTS=24;
  - typedef phase_idx_t (logic [4:0]);
  - typedef phi_code_t (logic [1:0]);
  - the function phi_to_base(phi_code_t) returning phase_idx_t.
- Sub-modules:
  - Instantiate the existing `cyc_24` lookup combinationally, driven from the next-index logic.
  - One natural new sub-module, pucch_mod24_add: computes (a+b) mod 24 for a, b < 24. It is used for both the accumulator update and the index sum.

Test Plan:
1. Constant phase: all codes 10 (+1), m_cs=0, i_ready=1.
   - Expect 12 beats on consecutive cycles starting the cycle after start.
   - Each beat: o_idx=3, o_re=0x5A82, o_im=0x5A82.
   - o_last only on beat 11; o_busy falls with it.
2. Cyclic shift: all codes 10, m_cs=1.
   - Expect o_idx = 3,5,7,9,11,13,15,17,19,21,23,1.
   - Beat 2 (idx 7): o_re=0xDEDF, o_im=0x7BA3.
3. Mixed codes and shift mod 12: codes n0=00, n1=11, remaining 01; m_cs=13 (treated as 1).
   - Expect idx0=15, idx1=9+2=11, idx2=21+4=25→1.
4. Backpressure: i_ready low for 3 cycles at beat 4.
   - o_valid stays high; o_idx, o_re, o_im are stable across the stall; no beat is skipped or duplicated; 12 total beats.
5. Control corner cases:
   - Reset asserted at beat 6: all outputs 0 immediately.
   - A new start afterwards begins cleanly at n=0.
   - i_start pulsed during RUN and on the last-accept cycle: ignored.
6. Conjugate (PUCCH_SEQ_CONJ_EN defined): codes 10, m_cs=0, i_conj=1.
   - Expect o_idx=21, o_re=0x5A82, o_im=0xA57E on every beat.
